// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, word data memory, MEM/WB register.
// Define MEM_STAGE_BYTE_ACCESS_EN to add sb/lb/lbu byte-lane access.
module mem_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        Clk_In,
  input  logic        Reset_In,
  input  logic        Stall_In,
  input  logic        Flush_In,
  input  logic [5:0]  Op_In,
  input  logic [5:0]  Func_In,
  input  logic [31:0] Aluresult_In,
  input  logic [31:0] Writedata_In,
  input  logic [4:0]  Regaddr_In,
  output logic [31:0] Mem_Aluresult_Out,
  output logic [4:0]  Mem_Regaddr_Out,
  output logic        Mem_Regwrite_Out,
  output logic        Mem_Isload_Out,
  output logic [31:0] Wb_Data_Out,
  output logic [4:0]  Wb_Regaddr_Out,
  output logic        Wb_Regwrite_Out
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
`endif

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } mem_wb_t;

  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  logic [31:0] mem [DEPTH];

  logic              writer;
  logic              is_lw;
  logic              is_sw;
  logic              is_sb;
  logic              is_lb;
  logic              is_lbu;
  logic              reg_we;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [31:0]       wb_data;

  always_ff @(posedge Clk_In) begin
    if (Reset_In)
      ex_mem <= '0;
    else if (Flush_In)
      ex_mem <= '0;
    else if (!Stall_In)
      ex_mem <= '{Op_In, Func_In, Aluresult_In,
                  Writedata_In, Regaddr_In};
  end

  always_comb begin
    writer = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_sb  = 1'b0;
    is_lb  = 1'b0;
    is_lbu = 1'b0;
    unique case (1'b1)
      ex_mem.op == OP_R &&
      (ex_mem.func == FN_ADDU ||
       ex_mem.func == FN_SUBU):  writer = 1'b1;
      ex_mem.op == OP_ORI:       writer = 1'b1;
      ex_mem.op == OP_LUI:       writer = 1'b1;
      ex_mem.op == OP_LW: begin
        writer = 1'b1;
        is_lw  = 1'b1;
      end
      ex_mem.op == OP_SW:        is_sw = 1'b1;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
      ex_mem.op == OP_SB:        is_sb = 1'b1;
      ex_mem.op == OP_LB: begin
        writer = 1'b1;
        is_lb  = 1'b1;
      end
      ex_mem.op == OP_LBU: begin
        writer = 1'b1;
        is_lbu = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign reg_we  = writer && (ex_mem.rd != 5'd0);
  assign idx     = ex_mem.alu[ADDR_W+1:2];
  assign lane    = ex_mem.alu[1:0];
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[8*lane +: 8];

  always_comb begin
    wb_data = ex_mem.alu;
    unique case (1'b1)
      is_lw:  wb_data = rd_word;
      is_lb:  wb_data = {{24{rd_byte[7]}}, rd_byte};
      is_lbu: wb_data = {24'd0, rd_byte};
      default: ;
    endcase
  end

  // A stalled store writes once, on the edge that releases it.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (!Stall_In) begin
      if (is_sw)
        mem[idx] <= ex_mem.wdata;
      if (is_sb)
        mem[idx][8*lane +: 8] <= ex_mem.wdata[7:0];
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In || Stall_In)
      mem_wb <= '0;
    else
      mem_wb <= '{wb_data, ex_mem.rd, reg_we};
  end

  assign Mem_Aluresult_Out = ex_mem.alu;
  assign Mem_Regaddr_Out   = ex_mem.rd;
  assign Mem_Regwrite_Out  = reg_we;
  assign Mem_Isload_Out    = is_lw | is_lb | is_lbu;
  assign Wb_Data_Out       = mem_wb.data;
  assign Wb_Regaddr_Out    = mem_wb.rd;
  assign Wb_Regwrite_Out   = mem_wb.we;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Byte-access vectors follow MEM_STAGE_BYTE_ACCESS_EN.
module tb_mem_stage;

  logic        Clk_In = 1'b0;
  logic        Reset_In = 1'b0;
  logic        Stall_In = 1'b0;
  logic        Flush_In = 1'b0;
  logic [5:0]  Op_In = '0;
  logic [5:0]  Func_In = '0;
  logic [31:0] Aluresult_In = '0;
  logic [31:0] Writedata_In = '0;
  logic [4:0]  Regaddr_In = '0;
  logic [31:0] Mem_Aluresult_Out;
  logic [4:0]  Mem_Regaddr_Out;
  logic        Mem_Regwrite_Out;
  logic        Mem_Isload_Out;
  logic [31:0] Wb_Data_Out;
  logic [4:0]  Wb_Regaddr_Out;
  logic        Wb_Regwrite_Out;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LUI  = 6'b001111;
  localparam logic [5:0] SB   = 6'b101000;
  localparam logic [5:0] LB   = 6'b100000;
  localparam logic [5:0] LBU  = 6'b100100;
  localparam logic [5:0] ADDU = 6'b100001;
  localparam logic [5:0] SUBU = 6'b100011;

  mem_stage #(.ADDR_W(10)) dut (
    .Clk_In(Clk_In),
    .Reset_In(Reset_In),
    .Stall_In(Stall_In),
    .Flush_In(Flush_In),
    .Op_In(Op_In),
    .Func_In(Func_In),
    .Aluresult_In(Aluresult_In),
    .Writedata_In(Writedata_In),
    .Regaddr_In(Regaddr_In),
    .Mem_Aluresult_Out(Mem_Aluresult_Out),
    .Mem_Regaddr_Out(Mem_Regaddr_Out),
    .Mem_Regwrite_Out(Mem_Regwrite_Out),
    .Mem_Isload_Out(Mem_Isload_Out),
    .Wb_Data_Out(Wb_Data_Out),
    .Wb_Regaddr_Out(Wb_Regaddr_Out),
    .Wb_Regwrite_Out(Wb_Regwrite_Out)
  );

  always #5 Clk_In = ~Clk_In;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [5:0] op,
                     input logic [5:0] fn,
                     input logic [31:0] alu,
                     input logic [31:0] wd,
                     input logic [4:0] rd);
    Op_In = op;
    Func_In = fn;
    Aluresult_In = alu;
    Writedata_In = wd;
    Regaddr_In = rd;
  endtask

  task automatic bubble();
    put(6'd0, 6'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge Clk_In);
    #1;
  endtask

  initial begin
    // reset then idle
    Reset_In = 1'b1;
    put(LW, 6'd0, 32'h44, 32'h1, 5'd7);
    tick();
    Reset_In = 1'b0;
    bubble();
    chk("rst_mem_alu", Mem_Aluresult_Out, 32'd0);
    chk("rst_mem_rd", {27'd0, Mem_Regaddr_Out}, 32'd0);
    chk("rst_mem_we", {31'd0, Mem_Regwrite_Out}, 32'd0);
    chk("rst_mem_ld", {31'd0, Mem_Isload_Out}, 32'd0);
    chk("rst_wb_data", Wb_Data_Out, 32'd0);
    chk("rst_wb_rd", {27'd0, Wb_Regaddr_Out}, 32'd0);
    chk("rst_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd0);

    // lw from cleared memory
    put(LW, 6'd0, 32'h40, 32'd0, 5'd5);
    tick();
    bubble();
    chk("lw0_mem_ld", {31'd0, Mem_Isload_Out}, 32'd1);
    chk("lw0_mem_we", {31'd0, Mem_Regwrite_Out}, 32'd1);
    chk("lw0_mem_alu", Mem_Aluresult_Out, 32'h40);
    tick();
    chk("lw0_wb_data", Wb_Data_Out, 32'd0);
    chk("lw0_wb_rd", {27'd0, Wb_Regaddr_Out}, 32'd5);
    chk("lw0_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd1);

    // sw then lw same address
    put(SW, 6'd0, 32'h10, 32'h12345678, 5'd0);
    tick();
    chk("sw_mem_we", {31'd0, Mem_Regwrite_Out}, 32'd0);
    chk("sw_mem_ld", {31'd0, Mem_Isload_Out}, 32'd0);
    put(LW, 6'd0, 32'h10, 32'd0, 5'd8);
    tick();
    bubble();
    chk("sw_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
    tick();
    chk("ls_wb_data", Wb_Data_Out, 32'h12345678);
    chk("ls_wb_rd", {27'd0, Wb_Regaddr_Out}, 32'd8);
    chk("ls_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd1);

    // ALU writers and r0 suppression
    put(6'd0, ADDU, 32'hFFFFFFFF, 32'd0, 5'd3);
    tick();
    chk("addu_mem_alu", Mem_Aluresult_Out, 32'hFFFFFFFF);
    chk("addu_mem_we", {31'd0, Mem_Regwrite_Out}, 32'd1);
    put(6'd0, ADDU, 32'hFFFFFFFF, 32'd0, 5'd0);
    tick();
    chk("addu_wb_data", Wb_Data_Out, 32'hFFFFFFFF);
    chk("addu_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd1);
    chk("addu_wb_rd", {27'd0, Wb_Regaddr_Out}, 32'd3);
    chk("r0_mem_we", {31'd0, Mem_Regwrite_Out}, 32'd0);
    put(6'd0, SUBU, 32'h00000123, 32'd0, 5'd6);
    tick();
    chk("r0_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
    put(ORI, 6'd0, 32'h00000077, 32'd0, 5'd4);
    tick();
    chk("subu_wb_data", Wb_Data_Out, 32'h123);
    chk("subu_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd1);
    put(LUI, 6'd0, 32'hBEEF0000, 32'd0, 5'd9);
    tick();
    chk("ori_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd1);
    chk("ori_wb_data", Wb_Data_Out, 32'h77);
    put(6'd0, 6'b100000, 32'h55, 32'd0, 5'd4);
    tick();
    chk("lui_wb_data", Wb_Data_Out, 32'hBEEF0000);
    chk("lui_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd1);
    put(6'b000010, 6'd0, 32'h66, 32'd0, 5'd4);
    tick();
    chk("add_nw_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
    bubble();
    tick();
    chk("j_nw_we", {31'd0, Wb_Regwrite_Out}, 32'd0);

    // stalled sw, release, then flush
    put(SW, 6'd0, 32'h20, 32'hAAAA0000, 5'd0);
    tick();
    Stall_In = 1'b1;
    put(6'd0, ADDU, 32'h99, 32'd0, 5'd9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stl_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
      chk("stl_wb_data", Wb_Data_Out, 32'd0);
      chk("stl_mem_alu", Mem_Aluresult_Out, 32'h20);
    end
    Stall_In = 1'b0;
    bubble();
    tick();
    chk("rel_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
    Flush_In = 1'b1;
    put(SW, 6'd0, 32'h20, 32'hDEADBEEF, 5'd0);
    tick();
    Flush_In = 1'b0;
    chk("fl_mem_alu", Mem_Aluresult_Out, 32'd0);
    put(LW, 6'd0, 32'h20, 32'd0, 5'd10);
    tick();
    bubble();
    tick();
    chk("stl_word8", Wb_Data_Out, 32'hAAAA0000);

    // address wrap
    put(SW, 6'd0, 32'h1000, 32'h5A, 5'd0);
    tick();
    put(LW, 6'd0, 32'h0, 32'd0, 5'd2);
    tick();
    bubble();
    tick();
    chk("wrap_data", Wb_Data_Out, 32'h5A);

    // reset mid-stall drops the pending sw and clears memory
    put(SW, 6'd0, 32'h30, 32'h77, 5'd0);
    tick();
    Stall_In = 1'b1;
    bubble();
    tick();
    Reset_In = 1'b1;
    tick();
    Reset_In = 1'b0;
    Stall_In = 1'b0;
    chk("rs_mem_alu", Mem_Aluresult_Out, 32'd0);
    chk("rs_wb_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
    put(LW, 6'd0, 32'h30, 32'd0, 5'd1);
    tick();
    put(LW, 6'd0, 32'h0, 32'd0, 5'd2);
    tick();
    chk("rs_nowrite", Wb_Data_Out, 32'd0);
    bubble();
    tick();
    chk("rs_memclr", Wb_Data_Out, 32'd0);

    // byte lanes
    put(SW, 6'd0, 32'h0, 32'h11223344, 5'd0);
    tick();
    put(SB, 6'd0, 32'h1, 32'h00000080, 5'd0);
    tick();
    put(LW, 6'd0, 32'h0, 32'd0, 5'd11);
    tick();
    put(LB, 6'd0, 32'h1, 32'd0, 5'd12);
    tick();
    put(LBU, 6'd0, 32'h1, 32'd0, 5'd13);
`ifdef MEM_STAGE_BYTE_ACCESS_EN
    chk("sb_word", Wb_Data_Out, 32'h11228044);
    chk("lb_mem_ld", {31'd0, Mem_Isload_Out}, 32'd1);
    tick();
    bubble();
    chk("lb_data", Wb_Data_Out, 32'hFFFFFF80);
    chk("lb_we", {31'd0, Wb_Regwrite_Out}, 32'd1);
    tick();
    chk("lbu_data", Wb_Data_Out, 32'h00000080);
    chk("lbu_we", {31'd0, Wb_Regwrite_Out}, 32'd1);
`else
    chk("sb_none", Wb_Data_Out, 32'h11223344);
    chk("lb_mem_ld", {31'd0, Mem_Isload_Out}, 32'd0);
    tick();
    bubble();
    chk("lb_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
    tick();
    chk("lbu_we", {31'd0, Wb_Regwrite_Out}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the five-stage MIPS pipeline, directly downstream of the ALU.
- Registers the ALU result and EX-stage control into an EX/MEM register.
- Performs the lw/sw access to an internal word-addressed data memory.
- Registers the write-back value into a MEM/WB register.
- Also exports the EX/MEM contents for forwarding back to EX.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2^ADDR_W 32-bit words.

Ports:
- Clk_In  input  1  clock; all state updates on rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Stall_In  input  1  hold EX/MEM register; MEM/WB receives a bubble.
- Flush_In  input  1  load a bubble into EX/MEM.
- Op_In  input  6  opcode of the instruction leaving EX.
- Func_In  input  6  function field (R-type) of the instruction leaving EX.
- Aluresult_In  input  32  ALU result: memory byte address for lw/sw, value otherwise.
- Writedata_In  input  32  rt value to store for sw (already forwarded).
- Regaddr_In  input  5  destination register chosen upstream.
- Mem_Aluresult_Out  output  32  EX/MEM ALU result (forwarding source).
- Mem_Regaddr_Out  output  5  EX/MEM destination register.
- Mem_Regwrite_Out  output  1  EX/MEM instruction will write a non-zero register.
- Mem_Isload_Out  output  1  EX/MEM instruction is a load (hazard-unit use).
- Wb_Data_Out  output  32  MEM/WB write-back value.
- Wb_Regaddr_Out  output  5  MEM/WB destination register.
- Wb_Regwrite_Out  output  1  MEM/WB register-file write enable.

Behaviour:
- Reset:
  - Precedence: reset > flush > stall.
  - EX/MEM and MEM/WB are cleared to all-zero.
  - All outputs read 0 in the cycle after the reset edge.
  - Every memory word is cleared to 0 at the same edge.
- Decode (of the EX/MEM-held Op/Func):
  - Writers: addu (op 000000, func 100001), subu (op 000000, func 100011), ori (001101), lui (001111), lw (100011).
  - sw (101011) and every other encoding write no register.
  - Regwrite is forced 0 when Regaddr = 0.
  - A bubble is op = func = 0, which decodes as a non-writer.
- EX/MEM register:
  - Normal: captures Op, Func, Aluresult, Writedata, Regaddr each edge.
  - Flush_In = 1: captures a bubble.
  - Stall_In = 1 (no flush): holds its contents.
  - Mem_* outputs are driven directly from this register.
- Memory addressing:
  - Word index = Mem_Aluresult[ADDR_W+1:2].
  - Upper bits are ignored, so the address wraps modulo the depth.
  - Address bits [1:0] are ignored; no alignment exception.
- Read: combinational from the EX/MEM address, valid in the same cycle.
- Write (sw):
  - Occurs at the rising edge where EX/MEM holds sw and Stall_In = 0 and Reset_In = 0.
  - A stalled sw therefore writes exactly once, on its releasing edge.
  - Flush does not suppress the write of the instruction currently in EX/MEM; flush affects only what enters.
- MEM/WB register:
  - Captures Wb_Data = memory read word for lw, otherwise Mem_Aluresult.
  - Also captures Regaddr and Regwrite.
  - When Stall_In = 1, captures a bubble (Regwrite 0, data 0, addr 0).
- Latency:
  - Instruction presented at edge N appears on Mem_* after N.
  - Its result appears on Wb_* after edge N+1.
  - lw data appears on Wb_Data_Out after edge N+1.
- Load-after-store, same address, consecutive instructions: the lw reads the value written by the sw (write at edge N+1, lw read during cycle N+2).
- Reset asserted mid-stall discards the held instruction; a pending sw is not written.

Optional Feature:
- Macro: MEM_STAGE_BYTE_ACCESS_EN.
- With it defined:
  - sb (101000) writes Writedata[7:0] into the byte lane selected by address bits [1:0], little-endian (lane 0 = bits 7:0); the other lanes are unchanged.
  - lb (100000) returns the selected byte sign-extended; lbu (100100) returns it zero-extended.
  - lb and lbu are register writers and assert Mem_Isload_Out.
- Without it: sb, lb and lbu decode as non-writers with no memory effect.

Test Plan:
- Reset then idle -> all outputs 0; lw of any address returns 0.
- sw 0x12345678 at address 0x10, then lw r8 from 0x10 next cycle -> Wb_Data_Out = 0x12345678, Wb_Regaddr_Out = 8, Wb_Regwrite_Out = 1, two edges after the lw is presented.
- addu result 0xFFFFFFFF to r3 -> Mem_Aluresult_Out = 0xFFFFFFFF after one edge; Wb_Data_Out = 0xFFFFFFFF, Wb_Regwrite_Out = 1 after two. Same with Regaddr 0 -> Wb_Regwrite_Out = 0.
- sw 0xAAAA0000 at 0x20 held by Stall_In for 3 cycles -> Wb_Regwrite_Out = 0 during the stall; memory word 8 = 0xAAAA0000 after release; a Flush_In in the following cycle leaves it intact.
- Address wrap with ADDR_W = 10: sw 0x5A to 0x1000, then lw from 0x0000 -> 0x0000005A.
- With MEM_STAGE_BYTE_ACCESS_EN: word 0 = 0x11223344; sb 0x80 at address 0x1 -> word = 0x11228044; lb at 0x1 -> 0xFFFFFF80; lbu at 0x1 -> 0x00000080.
